// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: word and register-address widths plus the
// writeback request record that travels from the result-select mux.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] regaddr_t;

  typedef struct packed {
    logic     valid;
    regaddr_t addr;
    word_t    data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_if.sv
// Writeback/read bus between the pipeline (master) and the register file (slave).
interface regfile_wb_if
  import cpu_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int AW = REG_AW
);
  // wb_valid qualifies wb_addr/wb_data for one cycle; there is no ready.
  // Back-pressure comes only from stall, which freezes the staged write.
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [N-1:0]  wb_data;
  logic          stall;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;

  modport master (
    output wb_valid, wb_addr, wb_data, stall, ra1, ra2,
    input  rd1, rd2, pend_valid, pend_addr
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, stall, ra1, ra2,
    output rd1, rd2, pend_valid, pend_addr
  );
endinterface

// File: rtl/wb_stage_reg.sv
// One-entry writeback staging register; holds its contents while stalled.
module wb_stage_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    stall,
  input  wb_req_t d,
  output wb_req_t q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Writeback register file: stages the mux result for one cycle, commits it
// to the array on the next unstalled edge, and forwards the staged value to reads.
module regfile_wb
  import cpu_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int REGS = 16
)(
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);
  localparam int AW = $clog2(REGS);

  wb_req_t      req;
  wb_req_t      pend;
  logic         commit;
  logic [N-1:0] regs [REGS];
  logic [N-1:0] rd1_v;
  logic [N-1:0] rd2_v;

  assign req = '{valid: bus.wb_valid, addr: bus.wb_addr, data: bus.wb_data};

  wb_stage_reg u_stage (
    .clk   (clk),
    .reset (reset),
    .stall (bus.stall),
    .d     (req),
    .q     (pend)
  );

  // The commit shares the edge with the staging load, so back-to-back writes
  // to the same address leave the younger value staged and the older stored.
  assign commit = !bus.stall && pend.valid && (pend.addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[pend.addr] <= pend.data;
    end
  end

  always_comb begin
    rd1_v = regs[bus.ra1];
    if (bus.ra1 == '0) begin
      rd1_v = '0;
    end else if (pend.valid && (bus.ra1 == pend.addr)) begin
      rd1_v = pend.data;
    end
  end

  always_comb begin
    rd2_v = regs[bus.ra2];
    if (bus.ra2 == '0) begin
      rd2_v = '0;
    end else if (pend.valid && (bus.ra2 == pend.addr)) begin
      rd2_v = pend.data;
    end
  end

  assign bus.rd1        = rd1_v;
  assign bus.rd2        = rd2_v;
  assign bus.pend_valid = pend.valid;
  assign bus.pend_addr  = pend.addr[AW-1:0];
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus a randomized
// run compared against a queue-based architectural model.
module tb_regfile_wb;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  regfile_wb_if #(.N(16), .AW(4)) bus ();

  regfile_wb #(.N(16), .REGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers plus a list of writes accepted
  // but not yet retired into the registers.
  logic [15:0] mem [16];
  wb_req_t     pend_q[$];

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] v;
    v = mem[a];
    foreach (pend_q[k]) if (pend_q[k].addr == a) v = pend_q[k].data;
    if (a == 4'd0) v = 16'h0000;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    pend_q.delete();
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d,
                       input logic s);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    bus.stall    = s;
  endtask

  task automatic set_reads(input logic [3:0] a1, input logic [3:0] a2);
    bus.ra1 = a1;
    bus.ra2 = a2;
    #1;
  endtask

  task automatic tick();
    wb_req_t e;
    @(posedge clk);
    if (!bus.stall) begin
      if (pend_q.size() > 0) begin
        e = pend_q.pop_front();
        if (e.addr != 4'd0) mem[e.addr] = e.data;
      end
      if (bus.wb_valid) pend_q.push_back('{valid: 1'b1, addr: bus.wb_addr, data: bus.wb_data});
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    set_reads(4'd0, 4'd0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      set_reads(a[3:0], 4'(15 - a));
      checks++;
      if (bus.rd1 !== 16'h0000 || bus.rd2 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read a=%0d rd1=%h rd2=%h expected 0000", a, bus.rd1, bus.rd2);
      end
    end
    checks++;
    if (bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend pend_valid=%b expected 0", bus.pend_valid);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd5, 16'h1234, 1'b0);
    set_reads(4'd5, 4'd0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (bus.rd1 !== 16'h1234 || bus.pend_valid !== 1'b1 || bus.pend_addr !== 4'd5) begin
      errors++;
      $display("FAIL wr_bypass rd1=%h pv=%b pa=%0d expected 1234/1/5",
               bus.rd1, bus.pend_valid, bus.pend_addr);
    end
    tick();
    checks++;
    if (bus.rd1 !== 16'h1234 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_array rd1=%h pv=%b expected 1234/0", bus.rd1, bus.pend_valid);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0);
    set_reads(4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (bus.rd1 !== 16'h0000 || bus.rd2 !== 16'h0000 || bus.pend_valid !== 1'b1) begin
      errors++;
      $display("FAIL r0_staged rd1=%h rd2=%h pv=%b expected 0000/0000/1",
               bus.rd1, bus.rd2, bus.pend_valid);
    end
    tick();
    checks++;
    if (bus.rd1 !== 16'h0000 || bus.rd2 !== 16'h0000 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL r0_after rd1=%h rd2=%h pv=%b expected 0000/0000/0",
               bus.rd1, bus.rd2, bus.pend_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd7, 16'hAAAA, 1'b0);
    set_reads(4'd0, 4'd7);
    tick();
    drive(1'b1, 4'd7, 16'h5555, 1'b0);
    #1;
    checks++;
    if (bus.rd2 !== 16'hAAAA) begin
      errors++;
      $display("FAIL b2b_first rd2=%h expected aaaa", bus.rd2);
    end
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (bus.rd2 !== 16'h5555) begin
      errors++;
      $display("FAIL b2b_second rd2=%h expected 5555", bus.rd2);
    end
    tick();
    checks++;
    if (bus.rd2 !== 16'h5555 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final rd2=%h pv=%b expected 5555/0", bus.rd2, bus.pend_valid);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'd9, 16'h0F0F, 1'b0);
    set_reads(4'd9, 4'd0);
    tick();
    // New requests offered while stalled must not displace the staged one.
    drive(1'b1, 4'd9, 16'h1111, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.rd1 !== 16'h0F0F || bus.pend_valid !== 1'b1 || bus.pend_addr !== 4'd9) begin
        errors++;
        $display("FAIL stall_hold c=%0d rd1=%h pv=%b pa=%0d expected 0f0f/1/9",
                 c, bus.rd1, bus.pend_valid, bus.pend_addr);
      end
      tick();
    end
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    tick();
    checks++;
    if (bus.rd1 !== 16'h0F0F || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release rd1=%h pv=%b expected 0f0f/0", bus.rd1, bus.pend_valid);
    end
  endtask

  task automatic test_dual_port();
    drive(1'b1, 4'd2, 16'h0002, 1'b0);
    tick();
    drive(1'b1, 4'd4, 16'h0004, 1'b0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    tick();
    set_reads(4'd2, 4'd4);
    checks++;
    if (bus.rd1 !== 16'h0002 || bus.rd2 !== 16'h0004) begin
      errors++;
      $display("FAIL dual_port rd1=%h rd2=%h expected 0002/0004", bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 4'd3, 16'hBEEF, 1'b0);
    tick();
    drive(1'b1, 4'd3, 16'hBEEF, 1'b0);
    tick();
    set_reads(4'd3, 4'd3);
    checks++;
    if (bus.rd1 !== 16'hBEEF || bus.pend_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre rd1=%h pv=%b expected beef/1", bus.rd1, bus.pend_valid);
    end
    // Assert reset between edges; outputs must clear with no clock edge.
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.rd1 !== 16'h0000 || bus.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async rd1=%h pv=%b expected 0000/0", bus.rd1, bus.pend_valid);
    end
    drive(1'b0, 4'd0, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (bus.rd1 !== 16'h0000) begin
      errors++;
      $display("FAIL midrun_after rd1=%h expected 0000", bus.rd1);
    end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            16'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
      set_reads(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      e1 = model_read(bus.ra1);
      e2 = model_read(bus.ra2);
      checks++;
      if (bus.rd1 !== e1 || bus.rd2 !== e2) begin
        errors++;
        $display("FAIL rand_read c=%0d ra1=%0d rd1=%h exp %h ra2=%0d rd2=%h exp %h",
                 c, bus.ra1, bus.rd1, e1, bus.ra2, bus.rd2, e2);
      end
      checks++;
      if (bus.pend_valid !== (pend_q.size() > 0) ||
          (pend_q.size() > 0 && bus.pend_addr !== pend_q[0].addr)) begin
        errors++;
        $display("FAIL rand_pend c=%0d pv=%b pa=%0d expected pv=%0d",
                 c, bus.pend_valid, bus.pend_addr, pend_q.size());
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_write_read();
    test_r0();
    test_back_to_back();
    test_stall();
    test_dual_port();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
